// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with a 1-cycle read.
// Commands are registered onto the RAM bus; read results are steered back to the issuing port.
module ram_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,

  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  // Handshake: a port holds req/we/addr/wdata stable until gnt is high in the
  // same cycle; the command transfers on that rising edge. Dropping req before
  // a grant simply discards the command.

  typedef struct packed {
    logic valid;
    logic port;
    logic is_read;
  } pipe_t;

  logic              last_gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  pipe_t             s1;
  pipe_t             s2;
  pipe_t             s1_next;

  // Under contention the port that did not win last time is granted.
  always_comb begin
    gnt0 = req0 & (~req1 | last_gnt);
    gnt1 = req1 & (~req0 | ~last_gnt);
  end

  always_comb begin
    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? we1    : we0;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
  end

  always_comb begin
    s1_next.valid   = any_gnt;
    s1_next.port    = gnt1;
    s1_next.is_read = any_gnt & ~sel_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (any_gnt) begin
      last_gnt <= gnt1;
    end
  end

  // Address and data hold between commands; only we drops when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else if (any_gnt) begin
      ram_we   <= sel_we;
      ram_addr <= sel_addr;
      ram_data <= sel_wdata;
    end else begin
      ram_we   <= 1'b0;
    end
  end

  // s1: command sits on the RAM bus; s2: RAM is producing q for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= s1_next;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= s2.valid & s2.is_read & ~s2.port;
      rvalid1 <= s2.valid & s2.is_read &  s2.port;
      if (s2.valid && s2.is_read && !s2.port) begin
        rdata0 <= ram_q;
      end
      if (s2.valid && s2.is_read && s2.port) begin
        rdata1 <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, shadow-memory reference model,
// per-port expected-read queues drained by an independent monitor.
module tb_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // ---------------- DUT ----------------
  logic          req0, we0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          req1, we1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q = '0;

  ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Single-port RAM, 1-cycle registered read, not affected by rst_n.
  logic [DW-1:0] ram_mem [64] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  int tests = 0;
  int fails = 0;

  logic [DW-1:0] shadow [64] = '{default: 8'h00};
  logic          m_last = 1'b1;
  logic          pend_valid = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;
  logic          exp_ram_we = 1'b0;
  logic [AW-1:0] exp_ram_addr = '0;
  logic [DW-1:0] exp_ram_data = '0;

  // Entry = {cycle at which rvalid is due, data}
  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [23:0] mon_e0, mon_e1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid0) begin
        if (exp_q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
        else begin
          mon_e0 = exp_q0.pop_front();
          chk("rdata0", rdata0, mon_e0[7:0]);
          chk("rvalid0_latency", cyc, mon_e0[23:8]);
        end
      end else if (exp_q0.size() > 0 && exp_q0[0][23:8] <= cyc) begin
        chk("rvalid0_missing", 0, 1);
        mon_e0 = exp_q0.pop_front();
      end
      if (rvalid1) begin
        if (exp_q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
        else begin
          mon_e1 = exp_q1.pop_front();
          chk("rdata1", rdata1, mon_e1[7:0]);
          chk("rvalid1_latency", cyc, mon_e1[23:8]);
        end
      end else if (exp_q1.size() > 0 && exp_q1[0][23:8] <= cyc) begin
        chk("rvalid1_missing", 0, 1);
        mon_e1 = exp_q1.pop_front();
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: check the RAM bus left by the previous edge, present the
  // requests, check the grant, and record what the grant should cause.
  task automatic cycle(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output logic g0, output logic g1);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    chk("ram_we", ram_we, exp_ram_we);
    chk("ram_addr", ram_addr, exp_ram_addr);
    chk("ram_data", ram_data, exp_ram_data);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    if (pend_valid) begin
      shadow[pend_addr] = pend_data;
      pend_valid = 1'b0;
    end
    g0 = r0 && (!r1 || m_last);
    g1 = r1 && (!r0 || !m_last);
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    exp_ram_we = 1'b0;
    if (g0 || g1) begin
      w = g1 ? w1 : w0;
      a = g1 ? a1 : a0;
      d = g1 ? d1 : d0;
      m_last = g1;
      exp_ram_we = w;
      exp_ram_addr = a;
      exp_ram_data = d;
      if (w) begin
        pend_valid = 1'b1;
        pend_addr = a;
        pend_data = d;
      end else if (g1) exp_q1.push_back({cyc + 16'd3, shadow[a]});
      else exp_q0.push_back({cyc + 16'd3, shadow[a]});
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
  endtask

  // Reset for one cycle, asserted just after the most recent grant edge.
  task automatic reset_mid();
    @(negedge clk);
    #2;
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q0.delete();
    exp_q1.delete();
    pend_valid = 1'b0;
    m_last = 1'b1;
    exp_ram_we = 1'b0; exp_ram_addr = '0; exp_ram_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) return AW'(63);
    return AW'($urandom_range(0, 63));
  endfunction

  // ---------------- stimulus ----------------
  logic          g0, g1;
  logic          h_r0, h_w0, h_r1, h_w1;
  logic [AW-1:0] h_a0, h_a1;
  logic [DW-1:0] h_d0, h_d1;

  initial begin
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Port 0 alone: writes then reads.
    cycle(1, 1, 6'd0, 8'h01, 0, 0, 6'd0, 8'h00, g0, g1);
    cycle(1, 1, 6'd1, 8'h02, 0, 0, 6'd0, 8'h00, g0, g1);
    cycle(1, 1, 6'd2, 8'h03, 0, 0, 6'd0, 8'h00, g0, g1);
    for (int i = 0; i < 3; i++) cycle(1, 0, AW'(i), 8'h00, 0, 0, 6'd0, 8'h00, g0, g1);

    // Both ports hold reads; grants alternate starting with port 0.
    reset_mid();
    repeat (6) cycle(1, 0, 6'd0, 8'h00, 1, 0, 6'd1, 8'h00, g0, g1);

    // Write on port 1, read same address on port 0 next cycle.
    cycle(0, 0, 6'd0, 8'h00, 1, 1, 6'd1, 8'h04, g0, g1);
    cycle(1, 0, 6'd1, 8'h00, 0, 0, 6'd0, 8'h00, g0, g1);

    // Simultaneous write (port 0) and read (port 1) of address 3.
    reset_mid();
    cycle(1, 1, 6'd3, 8'hAA, 1, 0, 6'd3, 8'h00, g0, g1);
    cycle(0, 0, 6'd0, 8'h00, 1, 0, 6'd3, 8'h00, g0, g1);

    // Reset right after a read grant: read is lost, port 0 wins next.
    cycle(1, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, g0, g1);
    reset_mid();
    cycle(1, 0, 6'd0, 8'h00, 1, 0, 6'd1, 8'h00, g0, g1);
    cycle(0, 0, 6'd0, 8'h00, 1, 0, 6'd1, 8'h00, g0, g1);

    // Address wrap.
    cycle(1, 1, 6'd63, 8'h5C, 0, 0, 6'd0, 8'h00, g0, g1);
    cycle(1, 0, 6'd63, 8'h00, 0, 0, 6'd0, 8'h00, g0, g1);
    cycle(1, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, g0, g1);

    // Randomized traffic with hold-until-grant, occasional drops and resets.
    h_r0 = 0; h_w0 = 0; h_a0 = '0; h_d0 = '0;
    h_r1 = 0; h_w1 = 0; h_a1 = '0; h_d1 = '0;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!h_r0 || g0) begin
        h_r0 = ($urandom_range(0, 3) != 0);
        h_w0 = $urandom_range(0, 1) == 1;
        h_a0 = pick_addr();
        h_d0 = DW'($urandom_range(0, 255));
      end else if ($urandom_range(0, 7) == 0) h_r0 = 1'b0;
      if (!h_r1 || g1) begin
        h_r1 = ($urandom_range(0, 3) != 0);
        h_w1 = $urandom_range(0, 1) == 1;
        h_a1 = pick_addr();
        h_d1 = DW'($urandom_range(0, 255));
      end else if ($urandom_range(0, 7) == 0) h_r1 = 1'b0;
      cycle(h_r0, h_w0, h_a0, h_d0, h_r1, h_w1, h_a1, h_d1, g0, g1);
      if (i % 200 == 199) begin
        reset_mid();
        h_r0 = 0; h_r1 = 0; g0 = 0; g1 = 0;
      end
    end

    // Drain and confirm every expected read came back.
    repeat (4) cycle(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, g0, g1);
    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single_port_ram (8-bit data, 6-bit address, 1-cycle read) between two requesters, port 0 and port 1.
- Round-robin arbitration accepts at most one command per cycle and drives the RAM's data/addr/we from registered outputs.
- Routes each read result back to the port that issued it, flagged with a per-port rvalid strobe.

Parameters:
- DATA_W, 8, data width; matches the RAM data/q width.
- ADDR_W, 6, address width; matches the RAM address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 command request.
- we0  in  1  port 0 command type: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 command accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as the port 0 signals, for port 1.
- ram_data  out  DATA_W  to RAM data.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_W  from RAM q.

Behaviour:

Reset (rst_n low):
- ram_we=0, ram_addr=0, ram_data=0.
- rvalid0=rvalid1=0, rdata0=rdata1=0.
- Issue pipeline cleared.
- Round-robin pointer last_gnt=1, so port 0 wins the first contention.

Handshake:
- A requester holds req/we/addr/wdata stable until it sees gnt high in the same cycle.
- The command transfers on that rising edge. The requester may present the next command in the following cycle.

Arbitration:
- gnt is combinational from req0, req1 and last_gnt. Exactly 0 or 1 grant per cycle.
- Only one port requesting: that port is granted.
- Both ports requesting: grant the port != last_gnt.
- last_gnt updates only on a granted edge.
- Back-to-back grants are allowed, giving 100% RAM utilisation when both ports request. Under contention the ports alternate strictly.

Command stage (registered):
- On a grant edge: ram_addr<=addr, ram_data<=wdata, ram_we<=we of the winner.
- With no grant: ram_we<=0; ram_addr and ram_data hold their values.

Write timing:
- A command granted at edge T is written to the RAM at edge T+1.

Read timing:
- The RAM samples ram_addr at edge T+1.
- ram_q is valid in cycle T+1..T+2. The arbiter registers ram_q at edge T+2.
- rvalid<port>=1 and rdata<port>=ram_q for exactly one cycle after edge T+2.
- Grant-to-rvalid latency is 2 clocks.

Issue pipeline:
- Two stages of {valid, port_id, is_read} carry ownership of each in-flight read.
- Writes produce no rvalid.
- rdata of the non-target port holds its previous value.

Hazards and boundaries:
- Read-after-write to the same address, granted on consecutive edges, returns the new data, because the write and the read address sample happen on different edges.
- A write and a read from different ports in consecutive cycles need no stall.
- Address wrap (2^ADDR_W-1 to 0) is plain truncation, with no special handling.
- A req dropped before grant is legal; the command is discarded.

Reset mid-operation:
- Asynchronous clear of everything listed under Reset.
- In-flight reads are lost and no rvalid is emitted for them.
- A pending write whose ram_we was high is cancelled if reset asserts before its edge.

Test Plan:
1. Port 0 alone: write 0x01@0, 0x02@1, 0x03@2 on consecutive grants, then read 0,1,2 -> gnt0 each cycle; rvalid0 two clocks after each read grant with rdata0=0x01,0x02,0x03; rvalid1 stays 0.
2. Both ports hold reads continuously (port 0 @0, port 1 @1) after reset -> grants alternate 0,1,0,1; rdata0=0x01 and rdata1=0x02 alternate every cycle with correct rvalid routing.
3. Port 1 writes 0x04@1; port 0 reads @1 in the next cycle -> rvalid0 with rdata0=0x04.
4. Simultaneous write (port 0, 0xAA@3) and read (port 1, @3) after reset -> port 0 granted first; port 1's read returns 0xAA.
5. Issue a read, then assert rst_n low for 1 cycle immediately after the grant -> no rvalid; all outputs 0; next contention grants port 0.
6. Write 0x5C@63, then read @63 and @0 -> rdata 0x5C, then the contents of address 0; ram_addr shows 63 then 0.
